// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter in front of a single Avalon-MM master port.
// Holds the command through waitrequest stalls and aborts stuck transfers with an error.
module mem_bus_arbiter #(
  parameter int unsigned MAX_WAIT = 255,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_req,
  input  logic        m0_write,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_be,
  output logic        m0_done,
  output logic        m0_err,
  output logic [31:0] m0_rdata,

  input  logic        m1_req,
  input  logic        m1_write,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_be,
  output logic        m1_done,
  output logic        m1_err,
  output logic [31:0] m1_rdata,

  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,

  output logic        busy,
  output logic        grant_id
);

  typedef enum logic [1:0] {StIdle, StIssue, StRdata} state_e;

  localparam logic [WAIT_W:0] MaxWaitCnt = (WAIT_W + 1)'(MAX_WAIT);

  state_e            state_q, state_d;
  logic [31:0]       address_q, address_d;
  logic [31:0]       writedata_q, writedata_d;
  logic [3:0]        byteenable_q, byteenable_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [1:0]        done_q, done_d;
  logic [1:0]        err_q, err_d;
  logic [31:0]       rdata_q [2];
  logic [31:0]       rdata_d [2];
  logic              busy_q, busy_d;
  logic              grant_id_q, grant_id_d;
  logic              last_grant_q, last_grant_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic [1:0]        elig;
  logic              gnt;
  logic [WAIT_W:0]   wait_inc;

  always_comb begin
    state_d      = state_q;
    address_d    = address_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    read_d       = read_q;
    write_d      = write_q;
    done_d       = '0;
    err_d        = '0;
    rdata_d[0]   = rdata_q[0];
    rdata_d[1]   = rdata_q[1];
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    wait_cnt_d   = wait_cnt_q;
    gnt          = 1'b0;
    // A port in its own done cycle is masked so the same request is not re-granted.
    elig         = {m1_req, m0_req} & ~done_q;
    wait_inc     = {1'b0, wait_cnt_q} + (WAIT_W + 1)'(1);

    unique case (state_q)
      StIdle: begin
        if (elig != 2'b00) begin
          gnt          = (elig == 2'b11) ? ~last_grant_q : elig[1];
          address_d    = gnt ? m1_addr  : m0_addr;
          writedata_d  = gnt ? m1_wdata : m0_wdata;
          byteenable_d = gnt ? m1_be    : m0_be;
          write_d      = gnt ? m1_write : m0_write;
          read_d       = ~write_d;
          grant_id_d   = gnt;
          last_grant_d = gnt;
          wait_cnt_d   = '0;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        if (!waitrequest) begin
          read_d     = 1'b0;
          write_d    = 1'b0;
          wait_cnt_d = '0;
          if (write_q) begin
            done_d[grant_id_q] = 1'b1;
            state_d            = StIdle;
          end else begin
            state_d = StRdata;
          end
        end else if (wait_inc == MaxWaitCnt) begin
          read_d              = 1'b0;
          write_d             = 1'b0;
          wait_cnt_d          = '0;
          done_d[grant_id_q]  = 1'b1;
          err_d[grant_id_q]   = 1'b1;
          rdata_d[grant_id_q] = '0;
          state_d             = StIdle;
        end else begin
          wait_cnt_d = wait_inc[WAIT_W-1:0];
        end
      end
      StRdata: begin
        rdata_d[grant_id_q] = readdata;
        done_d[grant_id_q]  = 1'b1;
        state_d             = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      address_q    <= '0;
      writedata_q  <= '0;
      byteenable_q <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      done_q       <= '0;
      err_q        <= '0;
      rdata_q[0]   <= '0;
      rdata_q[1]   <= '0;
      busy_q       <= 1'b0;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      read_q       <= read_d;
      write_q      <= write_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rdata_q[0]   <= rdata_d[0];
      rdata_q[1]   <= rdata_d[1];
      busy_q       <= busy_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign address    = address_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;
  assign read       = read_q;
  assign write      = write_q;
  assign m0_done    = done_q[0];
  assign m1_done    = done_q[1];
  assign m0_err     = err_q[0];
  assign m1_err     = err_q[1];
  assign m0_rdata   = rdata_q[0];
  assign m1_rdata   = rdata_q[1];
  assign busy       = busy_q;
  assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomised bench for mem_bus_arbiter: requesters and an Avalon slave are driven from $urandom,
// and a transfer-timeline model predicts every output cycle by cycle.
module tb_mem_bus_arbiter;

  localparam int MaxWait   = 8;
  localparam int NumCycles = 4000;
  localparam int SustainTo = 300;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_write, m1_req, m1_write;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_done, m0_err, m1_done, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] address, writedata, readdata;
  logic        read, write, waitrequest, busy, grant_id;
  logic [3:0]  byteenable;

  always #5 clk = ~clk;

  // Requester-side stimulus, one slot per port.
  logic        req_v  [2];
  logic        wr_v   [2];
  logic [31:0] addr_v [2];
  logic [31:0] wd_v   [2];
  logic [3:0]  be_v   [2];
  bit          pend     [2];
  bit          inflight [2];

  assign m0_req   = req_v[0];
  assign m0_write = wr_v[0];
  assign m0_addr  = addr_v[0];
  assign m0_wdata = wd_v[0];
  assign m0_be    = be_v[0];
  assign m1_req   = req_v[1];
  assign m1_write = wr_v[1];
  assign m1_addr  = addr_v[1];
  assign m1_wdata = wd_v[1];
  assign m1_be    = be_v[1];

  mem_bus_arbiter #(
    .MAX_WAIT (MaxWait),
    .WAIT_W   (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .m0_req      (m0_req),
    .m0_write    (m0_write),
    .m0_addr     (m0_addr),
    .m0_wdata    (m0_wdata),
    .m0_be       (m0_be),
    .m0_done     (m0_done),
    .m0_err      (m0_err),
    .m0_rdata    (m0_rdata),
    .m1_req      (m1_req),
    .m1_write    (m1_write),
    .m1_addr     (m1_addr),
    .m1_wdata    (m1_wdata),
    .m1_be       (m1_be),
    .m1_done     (m1_done),
    .m1_err      (m1_err),
    .m1_rdata    (m1_rdata),
    .address     (address),
    .read        (read),
    .write       (write),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .waitrequest (waitrequest),
    .readdata    (readdata),
    .busy        (busy),
    .grant_id    (grant_id)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Model: one active transfer described by its grant cycle and derived event times.
  bit          act;
  bit          in_rst;
  int          mport;
  bit          mwr;
  bit          merr;
  logic [31:0] maddr, mwd;
  logic [3:0]  mbe;
  int          t_wait_end, t_cmd_last, t_done;
  bit          last_g;
  bit          edone [2];
  bit          eerr  [2];
  logic [31:0] erd   [2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic int pick_stall();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 60) return 0;
    if (r < 82) return int'($urandom_range(1, 5));
    if (r < 93) return int'($urandom_range(6, MaxWait - 1));
    return int'($urandom_range(MaxWait, MaxWait + 3));
  endfunction

  task automatic grant_port(input int p);
    int k;
    k          = pick_stall();
    act        = 1'b1;
    mport      = p;
    mwr        = wr_v[p];
    maddr      = addr_v[p];
    mwd        = wd_v[p];
    mbe        = be_v[p];
    last_g     = (p == 1);
    inflight[p] = 1'b1;
    pend[p]     = 1'b0;
    if (k >= MaxWait) begin
      merr       = 1'b1;
      t_wait_end = cyc + MaxWait;
      t_cmd_last = cyc + MaxWait - 1;
      t_done     = cyc + MaxWait;
    end else begin
      merr       = 1'b0;
      t_wait_end = cyc + k;
      t_cmd_last = cyc + k;
      t_done     = cyc + k + (mwr ? 1 : 2);
    end
  endtask

  // Advance the model over the edge just taken, using the inputs sampled at that edge.
  task automatic model_edge();
    bit pd [2];
    bit e0, e1;
    pd[0]    = edone[0];
    pd[1]    = edone[1];
    edone[0] = 1'b0;
    edone[1] = 1'b0;
    eerr[0]  = 1'b0;
    eerr[1]  = 1'b0;
    in_rst   = !reset;
    if (!reset) begin
      act    = 1'b0;
      last_g = 1'b1;
      erd[0] = '0;
      erd[1] = '0;
      for (int p = 0; p < 2; p++) begin
        if (inflight[p]) begin
          inflight[p] = 1'b0;
          pend[p]     = 1'b1;
        end
      end
    end else if (act && cyc == t_done) begin
      act          = 1'b0;
      edone[mport] = 1'b1;
      eerr[mport]  = merr;
      if (merr) erd[mport] = '0;
      else if (!mwr) erd[mport] = readdata;
    end else if (!act) begin
      e0 = req_v[0] && !pd[0];
      e1 = req_v[1] && !pd[1];
      if (e0 && e1) grant_port(last_g ? 0 : 1);
      else if (e0) grant_port(0);
      else if (e1) grant_port(1);
    end
  endtask

  task automatic check_outputs();
    bit cmd;
    cmd = act && (cyc <= t_cmd_last);
    check_val("read", 32'(read), 32'(cmd && !mwr));
    check_val("write", 32'(write), 32'(cmd && mwr));
    if (cmd) begin
      check_val("address", address, maddr);
      check_val("writedata", writedata, mwd);
      check_val("byteenable", 32'(byteenable), 32'(mbe));
    end
    if (in_rst) begin
      check_val("rst_address", address, 32'h0);
      check_val("rst_writedata", writedata, 32'h0);
      check_val("rst_byteenable", 32'(byteenable), 32'h0);
      check_val("rst_grant_id", 32'(grant_id), 32'h0);
    end
    check_val("busy", 32'(busy), 32'(act));
    if (act) check_val("grant_id", 32'(grant_id), 32'(mport));
    check_val("m0_done", 32'(m0_done), 32'(edone[0]));
    check_val("m1_done", 32'(m1_done), 32'(edone[1]));
    check_val("m0_err", 32'(m0_err), 32'(eerr[0]));
    check_val("m1_err", 32'(m1_err), 32'(eerr[1]));
    check_val("m0_rdata", m0_rdata, erd[0]);
    check_val("m1_rdata", m1_rdata, erd[1]);
  endtask

  task automatic new_txn(input int p);
    pend[p]   = 1'b1;
    req_v[p]  = 1'b1;
    wr_v[p]   = 1'($urandom_range(0, 1));
    addr_v[p] = $urandom;
    wd_v[p]   = $urandom;
    be_v[p]   = 4'($urandom);
  endtask

  task automatic drive_inputs();
    bit sustained;
    sustained = (cyc < SustainTo);
    if (cyc < 3) reset = 1'b0;
    else if (!sustained && $urandom_range(0, 249) == 0) reset = 1'b0;
    else reset = 1'b1;

    if (act && cyc < t_wait_end) waitrequest = 1'b1;
    else if (act && cyc <= t_cmd_last) waitrequest = 1'b0;
    else waitrequest = 1'($urandom_range(0, 1));
    readdata = $urandom;

    for (int p = 0; p < 2; p++) begin
      if (edone[p]) begin
        inflight[p] = 1'b0;
        if (sustained || $urandom_range(0, 1) == 1) new_txn(p);
        else req_v[p] = 1'b0;
      end else if (inflight[p]) begin
        // Fields are only sampled at grant; garble them to prove the bus side latched them.
        if ($urandom_range(0, 1) == 1) begin
          wr_v[p]   = 1'($urandom_range(0, 1));
          addr_v[p] = $urandom;
          wd_v[p]   = $urandom;
          be_v[p]   = 4'($urandom);
        end
        if (!sustained && $urandom_range(0, 19) == 0) req_v[p] = 1'b0;
      end else if (pend[p]) begin
        req_v[p] = 1'b1;
      end else if (sustained || $urandom_range(0, 3) == 0) begin
        new_txn(p);
      end
    end
  endtask

  initial begin
    reset       = 1'b0;
    waitrequest = 1'b0;
    readdata    = '0;
    act         = 1'b0;
    in_rst      = 1'b0;
    last_g      = 1'b1;
    for (int p = 0; p < 2; p++) begin
      req_v[p]    = 1'b0;
      wr_v[p]     = 1'b0;
      addr_v[p]   = '0;
      wd_v[p]     = '0;
      be_v[p]     = '0;
      pend[p]     = 1'b0;
      inflight[p] = 1'b0;
      edone[p]    = 1'b0;
      eerr[p]     = 1'b0;
      erd[p]      = '0;
    end
    for (int c = 0; c < NumCycles; c++) begin
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      check_outputs();
      drive_inputs();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
